// File: rtl/game_pkg.sv
// Shared state encoding and default game tuning for the game state controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package game_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PLAY = 3'd1,
    HIT  = 3'd2,
    OVER = 3'd3,
    WON  = 3'd4
  } game_state_e;

  localparam int LIVES_INIT_DEF    = 3;
  localparam int INVULN_FRAMES_DEF = 120;
  localparam int NUM_ENEMIES_DEF   = 6;
  localparam int TIMER_W           = 8;

  // Kill count plus one, held at the win threshold.
  function automatic logic [2:0] kill_sat_inc(input logic [2:0] k, input logic [2:0] lim);
    kill_sat_inc = (k >= lim) ? lim : k + 3'd1;
  endfunction

endpackage

// File: rtl/frame_timer.sv
// Frame-based down-counter used for post-hit invulnerability; stops at zero.
// Latency: load or decrement visible on count one cycle after the edge.
// Backpressure: none; frame_tick pulses are consumed unconditionally.
module frame_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load,
  input  logic [W-1:0] value,
  input  logic         frame_tick,
  output logic [W-1:0] count,
  output logic         zero
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (load) begin
      count <= value;
    end else if (frame_tick && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/game_state_ctrl.sv
// Game flow FSM (IDLE/PLAY/HIT/OVER/WON) with lives, kills and respawn; GAME_BLINK_EN blinks the sprite in HIT.
// Latency: every output is registered and reflects the state entered on the edge that consumed the inputs.
// Backpressure: none; level and pulse inputs are sampled every cycle.
module game_state_ctrl
  import game_pkg::*;
#(
  parameter int LIVES_INIT    = LIVES_INIT_DEF,
  parameter int INVULN_FRAMES = INVULN_FRAMES_DEF,
  parameter int NUM_ENEMIES   = NUM_ENEMIES_DEF
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       frame_tick,
  input  logic       start,
  input  logic       death_signal,
  input  logic       kill_pulse,
  input  logic       restart,
  output logic [2:0] state,
  output logic       game_over,
  output logic       game_won,
  output logic       enemy_enable,
  output logic [1:0] lives,
  output logic [2:0] kills,
  output logic       respawn,
  output logic       bomberman_visible
);

  localparam logic [1:0]         LIVES_RST = 2'(LIVES_INIT);
  localparam logic [2:0]         KILLS_MAX = 3'(NUM_ENEMIES);
  localparam logic [TIMER_W-1:0] INV_LOAD  = TIMER_W'(INVULN_FRAMES);

  game_state_e        state_q, state_d;
  logic [1:0]         lives_d;
  logic [2:0]         kills_d;
  logic [2:0]         kills_inc;
  logic               kill_hit;
  logic               respawn_d;
  logic               vis_d;
  logic               timer_load;
  logic               tick_hit;
  logic [TIMER_W-1:0] timer_count;
  logic               timer_zero;

  assign kills_inc = kill_sat_inc(kills, KILLS_MAX);
  assign kill_hit  = kill_pulse && (kills != KILLS_MAX);
  assign tick_hit  = frame_tick && (state_q == HIT);

  frame_timer #(
    .W(TIMER_W)
  ) u_invuln_timer (
    .clk       (clk),
    .reset_n   (reset_n),
    .load      (timer_load),
    .value     (INV_LOAD),
    .frame_tick(tick_hit),
    .count     (timer_count),
    .zero      (timer_zero)
  );

  always_comb begin
    state_d    = state_q;
    lives_d    = lives;
    kills_d    = kills;
    respawn_d  = 1'b0;
    timer_load = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) state_d = PLAY;
      end
      PLAY: begin
        // A fatal hit swallows any kill arriving in the same cycle.
        if (death_signal && (lives <= 2'd1)) begin
          lives_d = 2'd0;
          state_d = OVER;
        end else begin
          if (death_signal) begin
            lives_d    = lives - 2'd1;
            respawn_d  = 1'b1;
            timer_load = 1'b1;
            state_d    = HIT;
          end
          if (kill_hit) begin
            kills_d = kills_inc;
            if (kills_inc == KILLS_MAX) state_d = WON;
          end
        end
      end
      HIT: begin
        if (timer_zero) state_d = PLAY;
        if (kill_hit) begin
          kills_d = kills_inc;
          if (kills_inc == KILLS_MAX) state_d = WON;
        end
      end
      OVER, WON: begin
        if (restart) begin
          state_d = IDLE;
          lives_d = LIVES_RST;
          kills_d = 3'd0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef GAME_BLINK_EN
  logic [TIMER_W-1:0] timer_next;

  // Mirror the counter's next value so the registered sprite enable lines up with the state.
  always_comb begin
    timer_next = timer_count;
    if (timer_load) begin
      timer_next = INV_LOAD;
    end else if (tick_hit && !timer_zero) begin
      timer_next = timer_count - 1'b1;
    end
  end

  assign vis_d = (state_d == HIT) ? timer_next[3] : 1'b1;
`else
  logic unused_timer_count;

  assign unused_timer_count = ^timer_count;
  assign vis_d              = 1'b1;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q           <= IDLE;
      lives             <= LIVES_RST;
      kills             <= 3'd0;
      respawn           <= 1'b0;
      game_over         <= 1'b0;
      game_won          <= 1'b0;
      enemy_enable      <= 1'b0;
      bomberman_visible <= 1'b1;
    end else begin
      state_q           <= state_d;
      lives             <= lives_d;
      kills             <= kills_d;
      respawn           <= respawn_d;
      game_over         <= (state_d == OVER);
      game_won          <= (state_d == WON);
      enemy_enable      <= (state_d == PLAY) || (state_d == HIT);
      bomberman_visible <= vis_d;
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_game_state_ctrl.sv
// Scoreboarded bench: directed game scenarios then random play against a rule-level model.
// Latency: n/a. Backpressure: n/a.
module tb_game_state_ctrl;

`ifdef GAME_BLINK_EN
  localparam int INV   = 16;
  localparam bit BLINK = 1'b1;
`else
  localparam int INV   = 4;
  localparam bit BLINK = 1'b0;
`endif
  localparam int LI = 3;
  localparam int NE = 6;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       frame_tick, start, death_signal, kill_pulse, restart;
  logic [2:0] state;
  logic       game_over, game_won, enemy_enable;
  logic [1:0] lives;
  logic [2:0] kills;
  logic       respawn, bomberman_visible;

  always #5 clk = ~clk;

  game_state_ctrl #(
    .LIVES_INIT   (LI),
    .INVULN_FRAMES(INV),
    .NUM_ENEMIES  (NE)
  ) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .frame_tick       (frame_tick),
    .start            (start),
    .death_signal     (death_signal),
    .kill_pulse       (kill_pulse),
    .restart          (restart),
    .state            (state),
    .game_over        (game_over),
    .game_won         (game_won),
    .enemy_enable     (enemy_enable),
    .lives            (lives),
    .kills            (kills),
    .respawn          (respawn),
    .bomberman_visible(bomberman_visible)
  );

  typedef struct packed {
    logic [2:0] st;
    logic       ov;
    logic       wn;
    logic       en;
    logic [1:0] lv;
    logic [2:0] kl;
    logic       rs;
    logic       vis;
  } obs_t;

  obs_t exp_q[$];
  obs_t mon_exp, mon_act;
  int   checks = 0;
  int   errors = 0;

  // Game-rule model: mode codes 0 idle, 1 playing, 2 invulnerable, 3 lost, 4 won.
  int m_mode, m_lives, m_kills, m_timer;
  bit m_resp;

  task automatic model_reset();
    m_mode  = 0;
    m_lives = LI;
    m_kills = 0;
    m_timer = 0;
    m_resp  = 1'b0;
  endtask

  task automatic count_kill(input bit k);
    if (k && m_kills < NE) begin
      m_kills = m_kills + 1;
      if (m_kills == NE) m_mode = 4;
    end
  endtask

  task automatic model_step(input bit s, input bit d, input bit k, input bit r, input bit t);
    m_resp = 1'b0;
    case (m_mode)
      0: if (s) m_mode = 1;
      1: begin
        if (d && m_lives == 1) begin
          m_lives = 0;
          m_mode  = 3;
        end else begin
          if (d) begin
            m_lives = m_lives - 1;
            m_resp  = 1'b1;
            m_timer = INV;
            m_mode  = 2;
          end
          count_kill(k);
        end
      end
      2: begin
        if (m_timer == 0) m_mode = 1;
        if (t && m_timer > 0) m_timer = m_timer - 1;
        count_kill(k);
      end
      default: begin
        if (r) begin
          m_mode  = 0;
          m_lives = LI;
          m_kills = 0;
        end
      end
    endcase
  endtask

  function automatic obs_t model_obs();
    obs_t o;
    o.st  = 3'(m_mode);
    o.ov  = (m_mode == 3);
    o.wn  = (m_mode == 4);
    o.en  = (m_mode == 1) || (m_mode == 2);
    o.lv  = 2'(m_lives);
    o.kl  = 3'(m_kills);
    o.rs  = m_resp;
    o.vis = (BLINK && m_mode == 2) ? m_timer[3] : 1'b1;
    return o;
  endfunction

  task automatic check(input string nm, input int act, input int exp);
    checks = checks + 1;
    if (act != exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // One clock: drive on the falling edge, predict on the rising edge.
  task automatic cyc(input bit s, input bit d, input bit k, input bit r, input bit t);
    @(negedge clk);
    start        = s;
    death_signal = d;
    kill_pulse   = k;
    restart      = r;
    frame_tick   = t;
    @(posedge clk);
    model_step(s, d, k, r, t);
    exp_q.push_back(model_obs());
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    {start, death_signal, kill_pulse, restart, frame_tick} = '0;
    reset_n = 1'b0;
    model_reset();
    exp_q.delete();
    #1;
    check("rst_state", int'(state), 0);
    check("rst_lives", int'(lives), LI);
    check("rst_kills", int'(kills), 0);
    check("rst_over", int'(game_over), 0);
    check("rst_won", int'(game_won), 0);
    check("rst_enable", int'(enemy_enable), 0);
    check("rst_respawn", int'(respawn), 0);
    check("rst_visible", int'(bomberman_visible), 1);
    repeat (2) @(negedge clk);
    #2;
    reset_n = 1'b1;
  endtask

  task automatic run_invuln_ticks();
    for (int i = 0; i < INV; i++) cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0);
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_exp = exp_q.pop_front();
      mon_act = '{state, game_over, game_won, enemy_enable, lives, kills, respawn, bomberman_visible};
      checks  = checks + 1;
      if (mon_act !== mon_exp) begin
        errors = errors + 1;
        $display("FAIL cycle_outputs at %0t: got st=%0d ov=%0b wn=%0b en=%0b lv=%0d kl=%0d rs=%0b vis=%0b, expected st=%0d ov=%0b wn=%0b en=%0b lv=%0d kl=%0d rs=%0b vis=%0b",
                 $time, mon_act.st, mon_act.ov, mon_act.wn, mon_act.en, mon_act.lv, mon_act.kl, mon_act.rs, mon_act.vis,
                 mon_exp.st, mon_exp.ov, mon_exp.wn, mon_exp.en, mon_exp.lv, mon_exp.kl, mon_exp.rs, mon_exp.vis);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int rc;
    bit s, d, k, r, t;
    {start, death_signal, kill_pulse, restart, frame_tick} = '0;
    reset_n = 1'b0;
    do_reset();

    // Start: IDLE -> PLAY.
    cyc(0, 0, 0, 0, 0);
    #1 check("idle_before_start", int'(state), 0);
    cyc(1, 0, 0, 0, 0);
    #1;
    check("start_state", int'(state), 1);
    check("start_lives", int'(lives), 3);
    check("start_enable", int'(enemy_enable), 1);

    // Held death: exactly one respawn, one life lost.
    rc = 0;
    for (int i = 0; i < 50; i++) begin
      cyc(0, 1, 0, 0, 0);
      #1 if (respawn) rc++;
    end
    check("hold_death_respawns", rc, 1);
    check("hold_death_lives", int'(lives), 2);
    check("hold_death_state", int'(state), 2);
`ifdef GAME_BLINK_EN
    check("blink_entry_vis", int'(bomberman_visible), 0);
`endif

    // Invulnerability expiry with death still asserted.
    for (int i = 1; i <= INV; i++) begin
      cyc(0, 1, 0, 0, 1);
      #1;
      check("invuln_tick_state", int'(state), 2);
`ifdef GAME_BLINK_EN
      if (i == 8) check("blink_after_8", int'(bomberman_visible), 1);
      if (i == 9) check("blink_after_9", int'(bomberman_visible), 0);
`else
      check("vis_in_hit", int'(bomberman_visible), 1);
`endif
    end
    cyc(0, 1, 0, 0, 0);
    #1;
    check("invuln_end_state", int'(state), 1);
    check("invuln_end_lives", int'(lives), 2);
    cyc(0, 0, 0, 0, 0);

    // Second and third deaths.
    cyc(0, 1, 0, 0, 0);
    #1;
    check("death2_respawn", int'(respawn), 1);
    check("death2_lives", int'(lives), 1);
    run_invuln_ticks();
    #1 check("death2_back_to_play", int'(state), 1);
    cyc(0, 1, 0, 0, 0);
    #1;
    check("death3_state", int'(state), 3);
    check("death3_lives", int'(lives), 0);
    check("death3_over", int'(game_over), 1);
    check("death3_no_respawn", int'(respawn), 0);
    repeat (3) cyc(1, 1, 1, 0, 1);
    cyc(0, 0, 0, 1, 0);
    #1;
    check("restart_from_over", int'(state), 0);
    check("restart_lives", int'(lives), 3);

    // Six kills, one coincident with a non-fatal death.
    cyc(1, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0);
    cyc(0, 0, 1, 0, 0);
    cyc(0, 1, 1, 0, 0);
    #1;
    check("coincident_kills", int'(kills), 3);
    check("coincident_lives", int'(lives), 2);
    check("coincident_state", int'(state), 2);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 0, 0, 0);
      cyc(0, 0, 1, 0, 0);
    end
    #1;
    check("win_kills", int'(kills), 6);
    check("win_state", int'(state), 4);
    check("win_flag", int'(game_won), 1);
    cyc(0, 0, 0, 1, 0);
    #1;
    check("restart_from_won", int'(state), 0);
    check("restart_kills", int'(kills), 0);
    check("restart_lives_won", int'(lives), 3);

    // Reset in the middle of invulnerability.
    cyc(1, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 1);
    do_reset();
    cyc(0, 0, 0, 0, 1);
    #1;
    check("post_reset_respawn", int'(respawn), 0);
    check("post_reset_state", int'(state), 0);

    // Random play.
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 599) == 0) do_reset();
      s = ($urandom_range(0, 3) == 0);
      d = ($urandom_range(0, 11) == 0);
      k = ($urandom_range(0, 7) == 0);
      r = ($urandom_range(0, 15) == 0);
      t = ($urandom_range(0, 2) == 0);
      cyc(s, d, k, r, t);
    end
    cyc(0, 0, 0, 0, 0);
    @(negedge clk);
    #1;
    check("scoreboard_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/game_state_ctrl.md
GAME_STATE_CTRL -- requirements
Module: game_state_ctrl

Interface
REQ-001 The block SHALL have parameter LIVES_INIT, default 3, number of lives at game start (1-3).
REQ-002 The block SHALL have parameter INVULN_FRAMES, default 120, frames of post-hit invulnerability (1-255).
REQ-003 The block SHALL have parameter NUM_ENEMIES, default 6, kills required to win (1-7).
REQ-004 The block SHALL have port clk, input, 1, the only clock, the 100 MHz system clock.
REQ-005 The block SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-006 The block SHALL have port frame_tick, input, 1, one-cycle pulse per VGA frame.
REQ-007 The block SHALL have port start, input, 1, level input; any direction button held.
REQ-008 The block SHALL have port death_signal, input, 1, level input; an enemy overlaps bomberman.
REQ-009 The block SHALL have port kill_pulse, input, 1, one-cycle pulse per enemy destroyed.
REQ-010 The block SHALL have port restart, input, 1, one-cycle pulse; the center-button SCEN.
REQ-011 The block SHALL have port state, output, 3, current FSM state code.
REQ-012 The block SHALL have port game_over, output, 1, high in OVER.
REQ-013 The block SHALL have port game_won, output, 1, high in WON.
REQ-014 The block SHALL have port enemy_enable, output, 1, high in PLAY and HIT.
REQ-015 The block SHALL have port lives, output, 2, remaining lives.
REQ-016 The block SHALL have port kills, output, 3, enemies destroyed.
REQ-017 The block SHALL have port respawn, output, 1, one-cycle pulse that returns bomberman to its start tile.
REQ-018 The block SHALL have port bomberman_visible, output, 1, sprite enable for the pixel mux.

Function
REQ-019 The FSM SHALL have five states: IDLE, PLAY, HIT, OVER and WON; all outputs SHALL be registered.
REQ-020 In IDLE, start=1 SHALL move the FSM to PLAY on the next edge.
REQ-021 In PLAY with death_signal=1 and lives>1, the block SHALL decrement lives, pulse respawn for 1 cycle, load the invulnerability counter with INVULN_FRAMES and go to HIT.
REQ-022 In PLAY with death_signal=1 and lives==1, the block SHALL set lives to 0 and go to OVER; respawn SHALL NOT pulse.
REQ-023 In HIT, the counter SHALL decrement on each frame_tick and death_signal SHALL be ignored.
REQ-024 In HIT, the FSM SHALL return to PLAY on the cycle after the counter reaches 0.
REQ-025 In PLAY and HIT, kill_pulse SHALL increment kills, saturating at NUM_ENEMIES.
REQ-026 When kills reaches NUM_ENEMIES, the FSM SHALL go to WON on the same edge.
REQ-027 If death_signal and kill_pulse occur in the same PLAY cycle, death SHALL be processed, and the kill SHALL still be counted unless the death sends the FSM to OVER.
REQ-028 In OVER and WON, restart SHALL move the FSM to IDLE, reload lives=LIVES_INIT and clear kills; all other inputs SHALL be ignored.
REQ-029 In IDLE, OVER and WON, kill_pulse and death_signal SHALL be ignored.
REQ-030 In IDLE, PLAY, OVER and WON, bomberman_visible SHALL be 1.

Reset
REQ-031 Asserting reset_n low SHALL immediately force: state=IDLE, lives=LIVES_INIT, kills=0, counter=0, game_over=0, game_won=0, enemy_enable=0, respawn=0, bomberman_visible=1.
REQ-032 A reset asserted mid-HIT SHALL abandon invulnerability with no respawn pulse.

Configuration
REQ-033 With GAME_BLINK_EN defined, bomberman_visible in HIT SHALL equal bit 3 of the counter, so it toggles every 8 frames.
REQ-034 Without GAME_BLINK_EN, bomberman_visible SHALL be 1 in every state and no blink logic SHALL be synthesized.

Structure
REQ-035 Package game_pkg SHALL hold the state encoding (IDLE=0, PLAY=1, HIT=2, OVER=3, WON=4) and the default LIVES_INIT, INVULN_FRAMES and NUM_ENEMIES constants.
REQ-036 The invulnerability down-counter SHALL be implemented as sub-module frame_timer, with ports load, value, frame_tick, count and zero.

Verification
REQ-037 The bench SHALL drive reset_n low, then high, then start=1 for 1 cycle, and SHALL check state goes IDLE->PLAY, lives=3 and enemy_enable=1.
REQ-038 The bench SHALL drive death_signal=1 for 50 cycles in PLAY, and SHALL check one respawn pulse, lives=2 and state=HIT.
REQ-039 With INVULN_FRAMES=4, the bench SHALL apply 4 frame_ticks in HIT, and SHALL check PLAY one cycle after the 4th tick, with death ignored throughout.
REQ-040 The bench SHALL drive three deaths separated by the invulnerability window, and SHALL check lives 3->2->1->0, OVER, game_over=1 and no respawn on the third death.
REQ-041 The bench SHALL drive 6 kill_pulses with one coincident with a non-fatal death, and SHALL check kills=6, WON and game_won=1, then that restart returns to IDLE with kills=0 and lives=3.
REQ-042 With GAME_BLINK_EN and INVULN_FRAMES=16, the bench SHALL check that bomberman_visible toggles after 8 frame_ticks in HIT; without the macro, it SHALL check bomberman_visible=1 throughout.
